// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp
// ----------------------------------------------------------------------------
// Parametrised multi-port register file with one write port and NUM_RD
// independent read ports.
//
// After reset, or when clr is accepted, a hardware sweep writes zero into
// every entry, one entry per cycle. While the sweep runs, busy is high, every
// read lane returns 0, and all writes are discarded. Any discarded write
// raises the sticky wr_drop flag.
//
// Read ports work in one of two modes:
//   * Combinational (SYNC_READ=0), with read-old behaviour. A write becomes
//     visible after its clock edge.
//   * Registered (SYNC_READ=1), with a write-first bypass. An accepted write
//     to the address a lane is presenting is captured directly.
//
// With ZERO_REG=1, entry 0 always reads 0. Writes to entry 0 are silently
// discarded and do not raise wr_drop.
//
// Parameters
//   DATA_W    entry width in bits
//   ADDR_W    address width
//   DEPTH     number of entries, 2 .. 2**ADDR_W
//   NUM_RD    number of read ports, 1 .. 8
//   SYNC_READ 0 = combinational read, 1 = registered read
//   ZERO_REG  1 = entry 0 hardwired to zero
//
// Ports
//   clock     sole clock, rising edge
//   reset_n   synchronous active-low reset
//   w_en      write enable
//   waddr     write address
//   wdata     write data
//   raddr     packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata     packed read data,      port i at [i*DATA_W +: DATA_W]
//   clr       single-cycle request to zero all entries
//   busy      clear sweep in progress
//   wr_drop   sticky flag, a write was discarded
// ============================================================================
module regfile_mp #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 16,
    parameter int NUM_RD    = 2,
    parameter int SYNC_READ = 0,
    parameter int ZERO_REG  = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       w_en,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    input  logic                       clr,
    output logic                       busy,
    output logic                       wr_drop
);

    // Index width of the storage array.
    // DEPTH <= 2**ADDR_W, so IDX_W never exceeds ADDR_W.
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened by one bit so that an address of all ones still compares
    // correctly when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [IDX_W-1:0]    mem_widx;
    logic [DATA_W-1:0]   mem_wdata;

    logic                wr_accept;
    logic                wr_reject;
    logic                clr_accept;

    logic [ADDR_W-1:0]   rd_addr [NUM_RD];
    logic [DATA_W-1:0]   rd_val  [NUM_RD];

    // True when the address refers to an existing entry.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_EXT);
    endfunction

    // True when the address is the hardwired zero entry.
    function automatic logic is_zero_entry(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // Reset restarts the sweep from entry 0, which also covers a reset that
    // arrives in the middle of a sweep.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // The sweep leaves CLEAR in the same cycle that it zeroes the last entry.
    // As a result, busy lasts exactly DEPTH cycles.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output and write-path logic
    // ------------------------------------------------------------------
    // Write-path rules:
    //   * clr has priority over a simultaneous write, so such a write counts
    //     as dropped.
    //   * A write to the hardwired zero entry is the only discarded write
    //     that leaves wr_drop alone.
    //   * When clr is accepted together with a write, the set wins. The flag
    //     is cleared by the clr and immediately re-set by the dropped write.
    always_comb begin
        busy       = (state_q == ST_CLEAR);
        clr_accept = (state_q == ST_IDLE) && clr;

        wr_accept  = (state_q == ST_IDLE) && w_en && !clr &&
                     in_range(waddr) && !is_zero_entry(waddr);

        wr_reject  = w_en && ((state_q == ST_CLEAR) || clr || !in_range(waddr));

        if (wr_reject) begin
            wr_drop_d = 1'b1;
        end else if (clr_accept) begin
            wr_drop_d = 1'b0;
        end else begin
            wr_drop_d = wr_drop_q;
        end

        // The sweep and user writes share the single memory write port.
        // They never collide, because user writes are blocked during a sweep.
        mem_we    = busy || wr_accept;
        mem_widx  = busy ? ptr_q[IDX_W-1:0] : waddr[IDX_W-1:0];
        mem_wdata = busy ? '0 : wdata;

        wr_drop   = wr_drop_q;
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // Memory has no reset of its own; the sweep that follows reset zeroes it.
    // Writes are held off during a reset edge so that the array only ever
    // changes through the sweep or through accepted writes.
    always_ff @(posedge clock) begin
        if (reset_n && mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read lookup
    // ------------------------------------------------------------------
    // A lane returns zero in three cases: the sweep is running, the address
    // is out of range, or the lane addresses the hardwired zero entry.
    // The slice into the array is safe because it is only used after the
    // range check.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr[i] = raddr[i*ADDR_W +: ADDR_W];
            rd_val[i]  = '0;
            if (!busy && in_range(rd_addr[i]) && !is_zero_entry(rd_addr[i])) begin
                rd_val[i] = mem_q[rd_addr[i][IDX_W-1:0]];
            end
        end
    end

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            logic [DATA_W-1:0] rdata_q [NUM_RD];
            logic [DATA_W-1:0] rdata_d [NUM_RD];

            // Write-first bypass: an accepted write to the address a lane is
            // presenting is captured directly. During a sweep, rd_val is zero
            // and no write is accepted, so the registers load zero.
            always_comb begin
                for (int i = 0; i < NUM_RD; i++) begin
                    rdata_d[i] = rd_val[i];
                    if (wr_accept && (waddr == rd_addr[i])) begin
                        rdata_d[i] = wdata;
                    end
                end
            end

            // Registered read data reloads on every edge.
            always_ff @(posedge clock) begin
                for (int i = 0; i < NUM_RD; i++) begin
                    if (!reset_n) begin
                        rdata_q[i] <= '0;
                    end else begin
                        rdata_q[i] <= rdata_d[i];
                    end
                end
            end

            // Pack the lane registers onto the output bus.
            always_comb begin
                rdata = '0;
                for (int i = 0; i < NUM_RD; i++) begin
                    rdata[i*DATA_W +: DATA_W] = rdata_q[i];
                end
            end
        end else begin : g_comb_read
            // Combinational read: the array output is presented directly,
            // so a write in the current cycle shows only after its edge.
            always_comb begin
                rdata = '0;
                for (int i = 0; i < NUM_RD; i++) begin
                    rdata[i*DATA_W +: DATA_W] = rd_val[i];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp
// ----------------------------------------------------------------------------
// Self-checking bench for regfile_mp with two instances:
//   A: DATA_W=4, ADDR_W=4, DEPTH=12, NUM_RD=2
//      combinational read, no zero entry
//   B: DATA_W=8, ADDR_W=5, DEPTH=20, NUM_RD=4
//      registered read, hardwired zero entry
//
// The reference model keeps each array as a plain integer array, a
// countdown of remaining sweep cycles, and the sticky drop flag.
// A sweep is modelled as "all entries become zero when the countdown ends".
// ============================================================================
module tb_regfile_mp;

    localparam int A_DW = 4, A_AW = 4, A_DEPTH = 12, A_NRD = 2;
    localparam int B_DW = 8, B_AW = 5, B_DEPTH = 20, B_NRD = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                    reset_n;

    logic                    a_w_en, a_clr, a_busy, a_wr_drop;
    logic [A_AW-1:0]         a_waddr;
    logic [A_DW-1:0]         a_wdata;
    logic [A_NRD*A_AW-1:0]   a_raddr;
    logic [A_NRD*A_DW-1:0]   a_rdata;

    logic                    b_w_en, b_clr, b_busy, b_wr_drop;
    logic [B_AW-1:0]         b_waddr;
    logic [B_DW-1:0]         b_wdata;
    logic [B_NRD*B_AW-1:0]   b_raddr;
    logic [B_NRD*B_DW-1:0]   b_rdata;

    regfile_mp #(
        .DATA_W(A_DW), .ADDR_W(A_AW), .DEPTH(A_DEPTH), .NUM_RD(A_NRD),
        .SYNC_READ(0), .ZERO_REG(0)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .w_en(a_w_en), .waddr(a_waddr),
        .wdata(a_wdata), .raddr(a_raddr), .rdata(a_rdata), .clr(a_clr),
        .busy(a_busy), .wr_drop(a_wr_drop)
    );

    regfile_mp #(
        .DATA_W(B_DW), .ADDR_W(B_AW), .DEPTH(B_DEPTH), .NUM_RD(B_NRD),
        .SYNC_READ(1), .ZERO_REG(1)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .w_en(b_w_en), .waddr(b_waddr),
        .wdata(b_wdata), .raddr(b_raddr), .rdata(b_rdata), .clr(b_clr),
        .busy(b_busy), .wr_drop(b_wr_drop)
    );

    // Reference model state
    int  a_mem [A_DEPTH];
    int  a_left;
    bit  a_drop;

    int  b_mem [B_DEPTH];
    int  b_left;
    bit  b_drop;
    int  b_rq [B_NRD];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  check_en = 1'b0;
    int  busy_cnt_a, busy_cnt_b;

    // Expected value of an instance-A lane: the current memory contents.
    function automatic int a_read(input int ra);
        if (a_left > 0 || ra >= A_DEPTH) return 0;
        return a_mem[ra];
    endfunction

    // Instance-B lookup; entry 0 always reads zero.
    function automatic int b_read(input int ra);
        if (b_left > 0 || ra >= B_DEPTH || ra == 0) return 0;
        return b_mem[ra];
    endfunction

    // Advance the instance-A model across one rising edge.
    task automatic stepModelA();
        if (!reset_n) begin
            a_left = A_DEPTH;
            a_drop = 1'b0;
        end else if (a_left > 0) begin
            if (a_w_en) a_drop = 1'b1;
            a_left--;
            if (a_left == 0) begin
                foreach (a_mem[k]) a_mem[k] = 0;
            end
        end else if (a_clr) begin
            a_drop = a_w_en;
            a_left = A_DEPTH;
        end else if (a_w_en) begin
            if (int'(a_waddr) >= A_DEPTH) a_drop = 1'b1;
            else a_mem[a_waddr] = int'(a_wdata);
        end
    endtask

    // Advance the instance-B model across one rising edge.
    // The registered lanes capture a value based on the state before the edge.
    task automatic stepModelB();
        int  nrq [B_NRD];
        bit  accepted;
        accepted = (b_left == 0) && !b_clr && b_w_en &&
                   int'(b_waddr) < B_DEPTH && b_waddr != 0;
        for (int i = 0; i < B_NRD; i++) begin
            nrq[i] = b_read(int'(b_raddr[i*B_AW +: B_AW]));
            if (accepted && b_raddr[i*B_AW +: B_AW] == b_waddr) nrq[i] = int'(b_wdata);
            b_rq[i] = reset_n ? nrq[i] : 0;
        end
        if (!reset_n) begin
            b_left = B_DEPTH;
            b_drop = 1'b0;
        end else if (b_left > 0) begin
            if (b_w_en) b_drop = 1'b1;
            b_left--;
            if (b_left == 0) begin
                foreach (b_mem[k]) b_mem[k] = 0;
            end
        end else if (b_clr) begin
            b_drop = b_w_en;
            b_left = B_DEPTH;
        end else if (b_w_en) begin
            if (int'(b_waddr) >= B_DEPTH) b_drop = 1'b1;
            else if (b_waddr != 0) b_mem[b_waddr] = int'(b_wdata);
        end
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic checkAll();
        checkOutput("a_busy", 32'(a_busy), 32'(a_left > 0));
        checkOutput("a_wr_drop", 32'(a_wr_drop), 32'(a_drop));
        for (int i = 0; i < A_NRD; i++)
            checkOutput($sformatf("a_rdata%0d", i), 32'(a_rdata[i*A_DW +: A_DW]),
                        32'(a_read(int'(a_raddr[i*A_AW +: A_AW]))));
        checkOutput("b_busy", 32'(b_busy), 32'(b_left > 0));
        checkOutput("b_wr_drop", 32'(b_wr_drop), 32'(b_drop));
        for (int i = 0; i < B_NRD; i++)
            checkOutput($sformatf("b_rdata%0d", i), 32'(b_rdata[i*B_DW +: B_DW]), 32'(b_rq[i]));
    endtask

    // One clock cycle. The caller sets the inputs while the clock is low.
    // Outputs are checked before the edge, the model then advances, and the
    // task returns on the next falling edge.
    task automatic applyStimulus();
        #1;
        if (check_en) checkAll();
        @(posedge clock);
        stepModelA();
        stepModelB();
        @(negedge clock);
    endtask

    // No writes or clears; the read addresses are random.
    task automatic idleInputs();
        a_w_en = 1'b0; a_clr = 1'b0; a_waddr = '0; a_wdata = '0;
        b_w_en = 1'b0; b_clr = 1'b0; b_waddr = '0; b_wdata = '0;
        a_raddr = (A_NRD*A_AW)'($urandom);
        b_raddr = (B_NRD*B_AW)'($urandom);
    endtask

    // Random traffic. Lanes sometimes alias the write address, and clr is
    // pulsed with probability 1/clr_one_in.
    task automatic randomInputs(input int clr_one_in);
        a_w_en  = 1'($urandom_range(0, 1));
        a_waddr = A_AW'($urandom);
        a_wdata = A_DW'($urandom);
        a_raddr = (A_NRD*A_AW)'($urandom);
        if ($urandom_range(0, 2) == 0) a_raddr[A_AW-1:0] = a_waddr;
        a_clr   = ($urandom_range(0, clr_one_in - 1) == 0);
        b_w_en  = 1'($urandom_range(0, 1));
        b_waddr = B_AW'($urandom);
        b_wdata = B_DW'($urandom);
        b_raddr = (B_NRD*B_AW)'($urandom);
        if ($urandom_range(0, 2) == 0) b_raddr[B_AW-1:0] = b_waddr;
        if ($urandom_range(0, 2) == 0) b_raddr[2*B_AW-1:B_AW] = b_waddr;
        b_clr   = ($urandom_range(0, clr_one_in - 1) == 0);
    endtask

    initial begin
        foreach (a_mem[k]) a_mem[k] = 0;
        foreach (b_mem[k]) b_mem[k] = 0;
        foreach (b_rq[k])  b_rq[k]  = 0;
        a_left = A_DEPTH; b_left = B_DEPTH; a_drop = 1'b0; b_drop = 1'b0;

        // Reset: the first edge sets the state; checks start on the second cycle.
        reset_n = 1'b0;
        idleInputs();
        applyStimulus();
        check_en = 1'b1;
        applyStimulus();

        // Release reset and let both sweeps finish.
        reset_n = 1'b1;
        for (int k = 0; k < B_DEPTH + 3; k++) begin
            idleInputs();
            applyStimulus();
        end

        // A: write 0xA to entry 3 with both lanes reading it.
        // B: write 0x07 to entry 5; lane 0 reads 5, lane 1 reads 6.
        idleInputs();
        a_w_en = 1'b1; a_waddr = 4'd3; a_wdata = 4'hA; a_raddr = {4'd3, 4'd3};
        b_w_en = 1'b1; b_waddr = 5'd5; b_wdata = 8'h07;
        b_raddr = {5'd5, 5'd5, 5'd6, 5'd5};
        applyStimulus();
        checkOutput("a_wr3_lane0", 32'(a_rdata[3:0]), 32'h0000_000A);
        checkOutput("a_wr3_lane1", 32'(a_rdata[7:4]), 32'h0000_000A);
        checkOutput("b_bypass_lane0", 32'(b_rdata[7:0]), 32'h0000_0007);
        checkOutput("b_bypass_lane1", 32'(b_rdata[15:8]), 32'h0000_0000);
        a_w_en = 1'b0; b_w_en = 1'b0;
        applyStimulus();

        // A: write to entry 13, which is out of range.
        // B: write to the hardwired zero entry.
        idleInputs();
        a_w_en = 1'b1; a_waddr = 4'd13; a_wdata = 4'hF; a_raddr = {4'd3, 4'd13};
        b_w_en = 1'b1; b_waddr = 5'd0; b_wdata = 8'hFF; b_raddr = '0;
        applyStimulus();
        checkOutput("a_oor_drop", 32'(a_wr_drop), 32'h1);
        checkOutput("a_oor_read", 32'(a_rdata[3:0]), 32'h0);
        checkOutput("b_zero_nodrop", 32'(b_wr_drop), 32'h0);
        checkOutput("b_zero_read", 32'(b_rdata[7:0]), 32'h0);
        a_w_en = 1'b0; b_w_en = 1'b0;
        applyStimulus();

        // Random traffic with occasional clears.
        for (int k = 0; k < 200; k++) begin
            randomInputs(30);
            applyStimulus();
        end
        for (int k = 0; k < B_DEPTH + 2; k++) begin
            idleInputs();
            applyStimulus();
        end

        // Fill every entry with 0x5.
        for (int k = 0; k < B_DEPTH; k++) begin
            idleInputs();
            a_w_en = (k < A_DEPTH); a_waddr = A_AW'(k); a_wdata = 4'h5;
            b_w_en = 1'b1;          b_waddr = B_AW'(k); b_wdata = 8'h05;
            applyStimulus();
        end

        // clr together with w_en: the sweep starts, and the dropped write
        // leaves wr_drop set.
        idleInputs();
        a_clr = 1'b1; a_w_en = 1'b1; a_waddr = 4'd2; a_wdata = 4'h9;
        b_clr = 1'b1; b_w_en = 1'b1; b_waddr = 5'd2; b_wdata = 8'h09;
        applyStimulus();
        checkOutput("a_clr_busy", 32'(a_busy), 32'h1);
        checkOutput("a_clr_drop", 32'(a_wr_drop), 32'h1);
        checkOutput("b_clr_busy", 32'(b_busy), 32'h1);
        checkOutput("b_clr_drop", 32'(b_wr_drop), 32'h1);
        for (int k = 0; k < B_DEPTH + 2; k++) begin
            idleInputs();
            applyStimulus();
        end

        // Every entry must read zero after the sweep.
        for (int k = 0; k < B_DEPTH + 1; k++) begin
            idleInputs();
            a_raddr = {A_AW'(k), A_AW'(k)};
            b_raddr = {B_AW'(k), B_AW'(k), B_AW'(k), B_AW'(k)};
            applyStimulus();
        end

        // Reset ten cycles into a sweep: the sweep restarts from the beginning.
        idleInputs();
        a_clr = 1'b1; b_clr = 1'b1;
        applyStimulus();
        for (int k = 0; k < 10; k++) begin
            idleInputs();
            applyStimulus();
        end
        reset_n = 1'b0;
        idleInputs();
        applyStimulus();
        reset_n = 1'b1;
        busy_cnt_a = 0;
        busy_cnt_b = 0;
        for (int k = 0; k < B_DEPTH + 5; k++) begin
            idleInputs();
            if (a_busy === 1'b1) busy_cnt_a++;
            if (b_busy === 1'b1) busy_cnt_b++;
            applyStimulus();
        end
        checkOutput("a_busy_len", 32'(busy_cnt_a), 32'(A_DEPTH));
        checkOutput("b_busy_len", 32'(busy_cnt_b), 32'(B_DEPTH));

        // Read back the last entry and entry 0 on every lane.
        idleInputs();
        a_w_en = 1'b1; a_waddr = 4'd11; a_wdata = 4'h6;
        b_w_en = 1'b1; b_waddr = 5'd19; b_wdata = 8'hC3;
        applyStimulus();
        idleInputs();
        a_w_en = 1'b1; a_waddr = 4'd0; a_wdata = 4'h3;
        a_raddr = {4'd11, 4'd11};
        b_raddr = {5'd19, 5'd19, 5'd19, 5'd19};
        applyStimulus();
        idleInputs();
        a_raddr = {4'd0, 4'd0};
        b_raddr = {5'd0, 5'd19, 5'd0, 5'd19};
        applyStimulus();
        checkOutput("a_last_entry_lane0", 32'(a_rdata[3:0]), 32'h3);
        checkOutput("b_last_entry_lane2", 32'(b_rdata[23:16]), 32'hC3);
        applyStimulus();

        // More random traffic, with occasional resets.
        for (int k = 0; k < 200; k++) begin
            randomInputs(25);
            reset_n = ($urandom_range(0, 59) != 0);
            applyStimulus();
        end
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
